// File: rtl/alu_pkg.sv
// Shared opcode encodings, request record and output-stage state for the ALU issue queue.
package alu_pkg;

  localparam logic [2:0] OPCODE_ADD = 3'b000;
  localparam logic [2:0] OPCODE_SUB = 3'b001;

  typedef logic [2:0] alu_op_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    alu_op_t     op;
  } alu_req_t;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_HELD  = 1'b1
  } out_state_t;

  function automatic logic op_is_legal(input alu_op_t op);
    return (op == OPCODE_ADD) || (op == OPCODE_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Request and result handshake bundle between producer, issue queue and writeback consumer.
interface alu_issue_queue_if #(
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  alu_op_t          in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/alu_req_fifo.sv
// Circular request/tag buffer; pushes while full and pops while empty are ignored.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  TAG_W = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  alu_req_t         push_req,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output alu_req_t         head_req,
  output logic [TAG_W-1:0] head_tag,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  alu_req_t         req_mem_r [DEPTH];
  logic [TAG_W-1:0] tag_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head_req  = req_mem_r[rd_ptr_r];
  assign head_tag  = tag_mem_r[rd_ptr_r];
  assign count     = count_r;

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      req_mem_r[wr_ptr_r] <= push_req;
      tag_mem_r[wr_ptr_r] <= push_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage for the 16-bit add/sub ALU: request FIFO, one issue per cycle, tagged result register.
// Optional ALU_ILLEGAL_OP_EN drops non-ADD/SUB requests at the input and pulses err_illegal.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  TAG_W = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_queue_if.slave    bus,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output alu_op_t             alu_op,
  output logic                alu_en,
  input  logic [15:0]         alu_result,
  output logic [CNT_W-1:0]    count,
  output logic                err_illegal
);

  alu_req_t         push_req_s;
  alu_req_t         head_req_s;
  logic [TAG_W-1:0] head_tag_s;
  logic             full_s;
  logic             empty_s;
  logic             accept_s;
  logic             legal_s;
  logic             push_s;
  logic             issue_s;

  out_state_t       state_r;
  logic             out_valid_r;
  logic [15:0]      result_r;
  logic [TAG_W-1:0] tag_r;

  assign accept_s     = bus.in_valid && !full_s;
  assign bus.in_ready = !full_s;
  assign push_s       = accept_s && legal_s;
  assign push_req_s   = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
  // A held result blocks issue until the consumer takes it.
  assign issue_s      = !empty_s && ((state_r == OUT_EMPTY) || bus.out_ready);

`ifdef ALU_ILLEGAL_OP_EN
  logic err_r;

  assign legal_s     = op_is_legal(bus.in_op);
  assign err_illegal = err_r;

  // Flag a request that completed its handshake but was dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= accept_s && !legal_s;
    end
  end
`else
  assign legal_s     = 1'b1;
  assign err_illegal = 1'b0;
`endif

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_req (push_req_s),
    .push_tag (bus.in_tag),
    .pop      (issue_s),
    .head_req (head_req_s),
    .head_tag (head_tag_s),
    .full     (full_s),
    .empty    (empty_s),
    .count    (count)
  );

  // ALU operands are forced to zero outside the issue cycle.
  always_comb begin
    if (issue_s) begin
      alu_en = 1'b1;
      alu_a  = head_req_s.a;
      alu_b  = head_req_s.b;
      alu_op = head_req_s.op;
    end else begin
      alu_en = 1'b0;
      alu_a  = 16'h0000;
      alu_b  = 16'h0000;
      alu_op = 3'b000;
    end
  end

  // Output stage: capture on issue, release when the consumer accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= OUT_EMPTY;
      out_valid_r <= 1'b0;
      result_r    <= 16'h0000;
      tag_r       <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        OUT_EMPTY: begin
          if (issue_s) begin
            state_r     <= OUT_HELD;
            out_valid_r <= 1'b1;
            result_r    <= alu_result;
            tag_r       <= head_tag_s;
          end else begin
            state_r     <= OUT_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        OUT_HELD: begin
          if (issue_s) begin
            state_r     <= OUT_HELD;
            out_valid_r <= 1'b1;
            result_r    <= alu_result;
            tag_r       <= head_tag_s;
          end else if (bus.out_ready) begin
            state_r     <= OUT_EMPTY;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= OUT_HELD;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= OUT_EMPTY;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = result_r;
  assign bus.out_tag    = tag_r;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural add/sub ALU on the issue port.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  alu_op_t     alu_op;
  logic        alu_en;
  logic [15:0] alu_result;
  logic [2:0]  count;
  logic        err_illegal;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_queue #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_en      (alu_en),
    .alu_result  (alu_result),
    .count       (count),
    .err_illegal (err_illegal)
  );

  // Reference ALU: add/sub, zero for undefined opcodes, carry dropped.
  always_comb begin
    case (alu_op)
      OPCODE_ADD: alu_result = alu_a + alu_b;
      OPCODE_SUB: alu_result = alu_a - alu_b;
      default:    alu_result = 16'h0000;
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input alu_op_t op,
                       input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_tag   = tag;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'h0000;
    bus.in_b      = 16'h0000;
    bus.in_op     = 3'b000;
    bus.in_tag    = 4'h0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_count", count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_err", err_illegal, 0);
    chk("rst_alu_en", alu_en, 0);
    rst = 1'b0;

    // single ADD: issue one cycle after acceptance, result the cycle after
    bus.out_ready = 1'b1;
    drive(16'h0003, 16'h0004, OPCODE_ADD, 4'd1);
    cyc();
    bus.in_valid = 1'b0;
    chk("t1_count", count, 1);
    chk("t1_alu_en", alu_en, 1);
    chk("t1_alu_a", alu_a, 16'h0003);
    chk("t1_alu_b", alu_b, 16'h0004);
    chk("t1_early_valid", bus.out_valid, 0);
    cyc();
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_result", bus.out_result, 16'h0007);
    chk("t1_tag", bus.out_tag, 1);
    chk("t1_count_after", count, 0);
    chk("t1_idle_alu_a", alu_a, 0);
    cyc();
    chk("t1_drained", bus.out_valid, 0);

    // wrap-around cases
    drive(16'h0000, 16'h0001, OPCODE_SUB, 4'd2);
    cyc();
    drive(16'hFFFF, 16'h0001, OPCODE_ADD, 4'd3);
    cyc();
    bus.in_valid = 1'b0;
    chk("t2_sub_valid", bus.out_valid, 1);
    chk("t2_sub_result", bus.out_result, 16'hFFFF);
    chk("t2_sub_tag", bus.out_tag, 2);
    cyc();
    chk("t2_add_result", bus.out_result, 16'h0000);
    chk("t2_add_tag", bus.out_tag, 3);
    cyc();
    chk("t2_drained", bus.out_valid, 0);

    // backpressure: fill FIFO behind a held result
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(16'h1000 + 16'(i), 16'h0010, OPCODE_ADD, 4'(i));
      cyc();
    end
    chk("t3_full_in_ready", bus.in_ready, 0);
    chk("t3_full_count", count, 4);
    chk("t3_held_valid", bus.out_valid, 1);
    chk("t3_held_tag", bus.out_tag, 0);
    drive(16'h1005, 16'h0010, OPCODE_ADD, 4'd5);
    cyc();
    bus.in_valid = 1'b0;
    chk("t3_no_push_full", count, 4);
    chk("t3_held_result", bus.out_result, 16'h1010);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_rel_valid", bus.out_valid, 1);
      chk("t3_rel_tag", bus.out_tag, 32'(i));
      chk("t3_rel_result", bus.out_result, 32'(16'h1010 + i));
      cyc();
    end
    chk("t3_drained", bus.out_valid, 0);
    chk("t3_count_empty", count, 0);

    // streaming: one result per cycle, occupancy never above one
    for (int i = 0; i < 6; i++) begin
      drive(16'(i), 16'(i), OPCODE_ADD, 4'(8 + i));
      cyc();
      chk("t4_count_le1", 32'(count <= 3'd1), 1);
      if (i >= 1) begin
        chk("t4_valid", bus.out_valid, 1);
        chk("t4_tag", bus.out_tag, 32'(8 + i - 1));
        chk("t4_result", bus.out_result, 32'(2 * (i - 1)));
      end
    end
    bus.in_valid = 1'b0;
    cyc();
    chk("t4_last_tag", bus.out_tag, 13);
    chk("t4_last_result", bus.out_result, 10);
    chk("t4_last_count", count, 0);
    cyc();
    chk("t4_drained", bus.out_valid, 0);

    // reset with work in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(16'h0100, 16'(i), OPCODE_SUB, 4'(i));
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("t5_pre_count", count, 3);
    chk("t5_pre_valid", bus.out_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_count", count, 0);
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    chk("t5_result", bus.out_result, 0);
    chk("t5_tag", bus.out_tag, 0);

    // undefined opcode
    bus.out_ready = 1'b1;
    drive(16'h1234, 16'h1111, 3'b111, 4'd7);
    chk("t6_in_ready", bus.in_ready, 1);
    cyc();
    bus.in_valid = 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
    chk("t6_err_pulse", err_illegal, 1);
    chk("t6_not_queued", count, 0);
    cyc();
    chk("t6_err_clear", err_illegal, 0);
    chk("t6_no_output", bus.out_valid, 0);
`else
    chk("t6_err_low", err_illegal, 0);
    chk("t6_queued", count, 1);
    cyc();
    chk("t6_valid", bus.out_valid, 1);
    chk("t6_result", bus.out_result, 0);
    chk("t6_tag", bus.out_tag, 7);
    chk("t6_err_still_low", err_illegal, 0);
`endif
    cyc();
    chk("t6_drained", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
